// File: rtl/vga_scope_pkg.sv
// Shared colours, capture FSM encodings and the amplitude-to-row mapping for the scope renderer.
// Palette alternates per channel: even channels green/cyan, odd channels yellow/magenta.
package vga_scope_pkg;

    localparam logic [2:0] BLACK   = 3'd0;
    localparam logic [2:0] GREEN   = 3'd2;
    localparam logic [2:0] CYAN    = 3'd3;
    localparam logic [2:0] MAGENTA = 3'd5;
    localparam logic [2:0] YELLOW  = 3'd6;

    localparam logic [1:0] ARMED   = 2'd0;
    localparam logic [1:0] CAPTURE = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    function automatic logic [2:0] pos_color(input int ch);
        return (ch % 2 == 0) ? GREEN : YELLOW;
    endfunction

    function automatic logic [2:0] neg_color(input int ch);
        return (ch % 2 == 0) ? CYAN : MAGENTA;
    endfunction

    // Row 0 is the top of the trace area, so positive amplitudes map upwards from the centre.
    function automatic int amp_to_row(input logic signed [31:0] amp, input int shift,
                                      input int height);
        int a_s;
        int lo;
        int hi;
        a_s = amp >>> shift;
        lo  = -(height / 2);
        hi  = height / 2 - 1;
        if (a_s < lo) begin
            a_s = lo;
        end else if (a_s > hi) begin
            a_s = hi;
        end
        return hi - a_s;
    endfunction

endpackage

// File: rtl/vga_scope_renderer_bank.sv
// Two-bank sample store: capture bank written by the FSM, display bank read with a 1-cycle registered port.
// Contents are not reset; the write and read bank selects are driven independently.
module scope_sample_bank
    import vga_scope_pkg::*;
#(
    parameter int DEPTH = 160,
    parameter int DAT_W = 32,
    parameter int A_W   = 8
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic             wbank_i,
    input  logic [A_W-1:0]   waddr_i,
    input  logic [DAT_W-1:0] wdat_i,
    input  logic             rbank_i,
    input  logic [A_W-1:0]   raddr_i,
    output logic [DAT_W-1:0] rdat_o
);

    logic [DAT_W-1:0] bank0_mem [DEPTH];
    logic [DAT_W-1:0] bank1_mem [DEPTH];
    logic [DAT_W-1:0] rdat_q;

    always_ff @(posedge clk_i) begin
        if (we_i && !wbank_i) begin
            bank0_mem[waddr_i] <= wdat_i;
        end
        if (we_i && wbank_i) begin
            bank1_mem[waddr_i] <= wdat_i;
        end
        rdat_q <= rbank_i ? bank1_mem[raddr_i] : bank0_mem[raddr_i];
    end

    assign rdat_o = rdat_q;

endmodule

// File: rtl/vga_scope_renderer.sv
// Scope renderer: triggered/decimated capture into a double-buffered store, 2-cycle pixel colour lookup.
// No backpressure, one pixel query per cycle; define TRACE_FILL_EN to join adjacent columns vertically.
module vga_scope_renderer
    import vga_scope_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int AMP_W        = 16,
    parameter int AMP_SHIFT    = 10,
    parameter int DEPTH        = 160,
    parameter int HEIGHT       = 60,
    parameter int DECIM        = 4,
    parameter int TRIG_TIMEOUT = 4096,
    parameter int X_W          = 8,
    parameter int Y_W          = 7
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    sample_valid_i,
    input  logic [NUM_CH*AMP_W-1:0] sample_data_i,
    input  logic                    frame_start_i,
    input  logic                    pix_valid_i,
    input  logic [X_W-1:0]          x_i,
    input  logic [Y_W-1:0]          y_i,
    output logic                    color_valid_o,
    output logic [2:0]              color_o,
    output logic                    triggered_o
);

    localparam int A_W   = $clog2(DEPTH);
    localparam int DAT_W = NUM_CH * AMP_W;
    localparam int TO_W  = $clog2(TRIG_TIMEOUT + 1);
    localparam int DC_W  = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [1:0]      state_q, state_d;
    logic [DC_W-1:0] dcnt_q, dcnt_d;
    logic [TO_W-1:0] tcnt_q, tcnt_d;
    logic [A_W-1:0]  waddr_q, waddr_d;
    logic            prev_neg_q, prev_neg_d;
    logic            prev_vld_q, prev_vld_d;
    logic            trig_flag_q, trig_flag_d;
    logic            disp_bank_q, disp_bank_d;
    logic            have_frame_q, have_frame_d;
    logic            triggered_q, triggered_d;

    logic            dec_smp;
    logic            cur_neg;
    logic            trig_hit;
    logic            tmo_hit;
    logic            wr_en;
    logic [A_W-1:0]  wr_addr;

    assign dec_smp  = sample_valid_i && (dcnt_q == '0);
    assign cur_neg  = sample_data_i[AMP_W-1];
    assign trig_hit = prev_vld_q && prev_neg_q && !cur_neg;
    assign tmo_hit  = (tcnt_q == TO_W'(TRIG_TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ARMED;
            dcnt_q       <= '0;
            tcnt_q       <= '0;
            waddr_q      <= '0;
            prev_neg_q   <= 1'b0;
            prev_vld_q   <= 1'b0;
            trig_flag_q  <= 1'b0;
            disp_bank_q  <= 1'b0;
            have_frame_q <= 1'b0;
            triggered_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            dcnt_q       <= dcnt_d;
            tcnt_q       <= tcnt_d;
            waddr_q      <= waddr_d;
            prev_neg_q   <= prev_neg_d;
            prev_vld_q   <= prev_vld_d;
            trig_flag_q  <= trig_flag_d;
            disp_bank_q  <= disp_bank_d;
            have_frame_q <= have_frame_d;
            triggered_q  <= triggered_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        dcnt_d       = dcnt_q;
        tcnt_d       = tcnt_q;
        waddr_d      = waddr_q;
        prev_neg_d   = prev_neg_q;
        prev_vld_d   = prev_vld_q;
        trig_flag_d  = trig_flag_q;
        disp_bank_d  = disp_bank_q;
        have_frame_d = have_frame_q;
        triggered_d  = triggered_q;

        if (sample_valid_i) begin
            dcnt_d = (dcnt_q == DC_W'(DECIM - 1)) ? '0 : dcnt_q + 1'b1;
        end

        case (state_q)
            ARMED: begin
                if (dec_smp) begin
                    prev_neg_d = cur_neg;
                    prev_vld_d = 1'b1;
                    if (trig_hit || tmo_hit) begin
                        state_d     = CAPTURE;
                        trig_flag_d = trig_hit;
                        waddr_d     = A_W'(1);
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            CAPTURE: begin
                if (dec_smp) begin
                    if (waddr_q == A_W'(DEPTH - 1)) begin
                        state_d = DONE;
                    end else begin
                        waddr_d = waddr_q + 1'b1;
                    end
                end
            end
            DONE: begin
                // Swapping only here keeps the displayed bank stable for a whole frame.
                if (frame_start_i) begin
                    state_d      = ARMED;
                    disp_bank_d  = ~disp_bank_q;
                    have_frame_d = 1'b1;
                    triggered_d  = trig_flag_q;
                    dcnt_d       = '0;
                    tcnt_d       = '0;
                    prev_vld_d   = 1'b0;
                end
            end
            default: state_d = ARMED;
        endcase
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = waddr_q;
        if (state_q == ARMED) begin
            wr_en   = dec_smp && (trig_hit || tmo_hit);
            wr_addr = '0;
        end else if (state_q == CAPTURE) begin
            wr_en = dec_smp;
        end
    end

    logic             x_in;
    logic             y_in;
    logic [A_W-1:0]   rd_addr;
    logic [DAT_W-1:0] rd_dat;

    assign x_in    = int'(x_i) < DEPTH;
    assign y_in    = int'(y_i) < HEIGHT;
    assign rd_addr = x_in ? A_W'(x_i) : '0;

    scope_sample_bank #(
        .DEPTH (DEPTH),
        .DAT_W (DAT_W),
        .A_W   (A_W)
    ) u_bank (
        .clk_i   (clk_i),
        .we_i    (wr_en),
        .wbank_i (~disp_bank_q),
        .waddr_i (wr_addr),
        .wdat_i  (sample_data_i),
        .rbank_i (disp_bank_q),
        .raddr_i (rd_addr),
        .rdat_o  (rd_dat)
    );

    logic           s1_vld_q;
    logic           s1_xin_q;
    logic           s1_yin_q;
    logic [Y_W-1:0] s1_y_q;
    logic           color_valid_q;
    logic [2:0]     color_q, color_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_vld_q      <= 1'b0;
            s1_xin_q      <= 1'b0;
            s1_yin_q      <= 1'b0;
            s1_y_q        <= '0;
            color_valid_q <= 1'b0;
            color_q       <= BLACK;
        end else begin
            s1_vld_q      <= pix_valid_i;
            s1_xin_q      <= x_in;
            s1_yin_q      <= y_in;
            s1_y_q        <= y_i;
            color_valid_q <= s1_vld_q;
            color_q       <= color_d;
        end
    end

    logic [Y_W-1:0]    row [NUM_CH];
    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] pos;

`ifdef TRACE_FILL_EN
    logic [X_W-1:0] s1_x_q;
    logic [X_W-1:0] last_x_q;
    logic           last_vld_q;
    logic [Y_W-1:0] last_row_q [NUM_CH];
    logic           fill_ok;

    // Only a query for the immediately preceding column may extend the trace.
    assign fill_ok = last_vld_q && s1_xin_q && (s1_x_q == last_x_q + 1'b1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_x_q     <= '0;
            last_x_q   <= '0;
            last_vld_q <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                last_row_q[c] <= '0;
            end
        end else begin
            s1_x_q <= x_i;
            if (s1_vld_q) begin
                last_x_q   <= s1_x_q;
                last_vld_q <= s1_xin_q;
                for (int c = 0; c < NUM_CH; c++) begin
                    last_row_q[c] <= row[c];
                end
            end
        end
    end
`endif

    always_comb begin
        logic signed [AMP_W-1:0] smp;
        logic                    span;
        smp  = '0;
        span = 1'b0;
        hit  = '0;
        pos  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            smp    = rd_dat[c*AMP_W +: AMP_W];
            row[c] = Y_W'(amp_to_row(32'(smp), AMP_SHIFT, HEIGHT));
            pos[c] = !smp[AMP_W-1] && (smp != '0);
            span   = 1'b0;
`ifdef TRACE_FILL_EN
            if (fill_ok) begin
                if (last_row_q[c] <= row[c]) begin
                    span = (s1_y_q >= last_row_q[c]) && (s1_y_q <= row[c]);
                end else begin
                    span = (s1_y_q >= row[c]) && (s1_y_q <= last_row_q[c]);
                end
            end
`endif
            hit[c] = (row[c] == s1_y_q) || span;
        end
    end

    always_comb begin
        color_d = BLACK;
        // Walk downwards so the lowest-index hitting channel is the last to assign.
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (hit[c]) begin
                color_d = pos[c] ? pos_color(c) : neg_color(c);
            end
        end
        if (!s1_vld_q || !s1_xin_q || !s1_yin_q || !have_frame_q) begin
            color_d = BLACK;
        end
    end

    assign color_valid_o = color_valid_q;
    assign color_o       = color_q;
    assign triggered_o   = triggered_q;

endmodule

// File: tb/tb_vga_scope_renderer.sv
// Directed bench for vga_scope_renderer (DECIM=1): reset, triggered/forced capture, scaling, priority, fill.
module tb_vga_scope_renderer;

    localparam logic [2:0] C_BLACK   = 3'd0;
    localparam logic [2:0] C_GREEN   = 3'd2;
    localparam logic [2:0] C_CYAN    = 3'd3;
    localparam logic [2:0] C_MAGENTA = 3'd5;
    localparam logic [2:0] C_YELLOW  = 3'd6;
    localparam logic signed [15:0] NEG_FS = 16'sh8000;
`ifdef TRACE_FILL_EN
    localparam logic [2:0] FILL_EXP = C_GREEN;
`else
    localparam logic [2:0] FILL_EXP = C_BLACK;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [31:0] sample_data = '0;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [7:0]  x = '0;
    logic [6:0]  y = '0;
    logic        color_valid;
    logic [2:0]  color;
    logic        triggered;

    int total = 0;
    int bad = 0;

    logic signed [15:0] b0 [160];
    logic signed [15:0] b1 [160];

    always #5 clk = ~clk;

    vga_scope_renderer #(.DECIM(1)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .sample_valid_i (sample_valid),
        .sample_data_i  (sample_data),
        .frame_start_i  (frame_start),
        .pix_valid_i    (pix_valid),
        .x_i            (x),
        .y_i            (y),
        .color_valid_o  (color_valid),
        .color_o        (color),
        .triggered_o    (triggered)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic signed [15:0] c0, input logic signed [15:0] c1);
        @(negedge clk);
        sample_valid = 1'b1;
        sample_data  = {c1, c0};
    endtask

    task automatic stop_samples();
        @(negedge clk);
        sample_valid = 1'b0;
        frame_start  = 1'b0;
    endtask

    task automatic pulse_fs();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic pix(input int px, input int py, input logic [2:0] exp, input string tag);
        @(negedge clk);
        pix_valid = 1'b1;
        x = 8'(px);
        y = 7'(py);
        @(negedge clk);
        pix_valid = 1'b0;
        check({tag, "_lat"}, 32'(color_valid), 32'd0);
        @(negedge clk);
        check({tag, "_cv"}, 32'(color_valid), 32'd1);
        check(tag, 32'(color), 32'(exp));
    endtask

    task automatic pix_pair(input int x0, input int y0, input int x1, input int y1,
                            input logic [2:0] exp, input string tag);
        @(negedge clk);
        pix_valid = 1'b1;
        x = 8'(x0);
        y = 7'(y0);
        @(negedge clk);
        x = 8'(x1);
        y = 7'(y1);
        @(negedge clk);
        pix_valid = 1'b0;
        @(negedge clk);
        check(tag, 32'(color), 32'(exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int j = 0; j < 160; j++) begin
            b0[j] = NEG_FS;
            b1[j] = 16'sd0;
        end
        b0[0] = 16'sd0;
        b0[2] = 16'sd19456;  b1[2] = 16'sd19456;
        b1[3] = 16'sd19456;
        b0[4] = -16'sd1;
        b0[5] = 16'sd19456;
        b0[6] = 16'sd9216;
        b0[7] = 16'sd1;

        // Reset state and empty-display queries
        repeat (3) @(negedge clk);
        check("rst_color", 32'(color), 32'd0);
        check("rst_cv", 32'(color_valid), 32'd0);
        check("rst_trig", 32'(triggered), 32'd0);
        rst_n = 1'b1;
        pix(0, 29, C_BLACK, "empty_0_29");
        pix(159, 0, C_BLACK, "empty_159_0");

        // Frame A: ramp triggers on the zero sample; frame_start on the last write must not swap
        for (int i = 0; i < 162; i++) begin
            int v;
            v = -2048 + 1024 * i;
            if (v > 32767) v = 32767;
            send(16'(v), NEG_FS);
            if (i == 161) frame_start = 1'b1;
        end
        stop_samples();
        pix(0, 29, C_BLACK, "a_noswap");
        check("a_trig_pre", 32'(triggered), 32'd0);
        pulse_fs();
        check("a_trig", 32'(triggered), 32'd1);
        pix(0, 29, C_CYAN, "a_0_29");
        pix(1, 28, C_GREEN, "a_1_28");
        pix(1, 29, C_BLACK, "a_1_29");
        pix(40, 0, C_GREEN, "a_clip_top");
        pix(5, 24, C_GREEN, "a_5_24");
        pix(5, 59, C_MAGENTA, "a_ch1_59");

        // Frame C: DC input forces a capture after the timeout
        for (int i = 0; i < 4266; i++) begin
            send(16'sd5120, NEG_FS);
        end
        stop_samples();
        pix(0, 29, C_CYAN, "c_hold");
        pulse_fs();
        check("c_trig", 32'(triggered), 32'd0);
        pix(0, 24, C_GREEN, "c_0_24");
        pix(100, 24, C_GREEN, "c_100_24");
        pix(100, 59, C_MAGENTA, "c_100_59");
        pix(0, 29, C_BLACK, "c_0_29");

        // Frame B: clipping, sign, channel priority and range limits
        send(-16'sd1024, 16'sd0);
        for (int j = 0; j < 160; j++) begin
            send(b0[j], b1[j]);
        end
        stop_samples();
        pix(0, 24, C_GREEN, "b_hold");
        pulse_fs();
        check("b_trig", 32'(triggered), 32'd1);
        pix(0, 29, C_CYAN, "b_prio_0_29");
        pix(0, 59, C_BLACK, "b_0_59");
        pix(10, 59, C_CYAN, "b_clip_bot");
        pix(10, 29, C_MAGENTA, "b_ch1_29");
        pix(2, 10, C_GREEN, "b_prio_2_10");
        pix(3, 10, C_YELLOW, "b_ch1_3_10");
        pix(3, 59, C_CYAN, "b_3_59");
        pix(4, 30, C_CYAN, "b_neg1");
        pix(7, 29, C_GREEN, "b_pos1");
        pix(159, 59, C_CYAN, "b_last_col");
        pix(160, 29, C_BLACK, "b_x_oob");
        pix(10, 60, C_BLACK, "b_y_oob");

        // Column 5 row 10 followed by column 6 row 20
        pix_pair(5, 10, 6, 15, FILL_EXP, "fill_mid");
        pix_pair(5, 10, 6, 10, FILL_EXP, "fill_end");
        pix_pair(5, 10, 6, 20, C_GREEN, "fill_point");
        pix_pair(5, 10, 6, 21, C_BLACK, "fill_above");
        pix_pair(0, 0, 6, 15, C_BLACK, "fill_nonseq");

        // Reset in the middle of a capture drops both the partial and the displayed frame
        send(-16'sd1024, 16'sd0);
        for (int i = 0; i < 50; i++) begin
            send(16'sd0, 16'sd0);
        end
        stop_samples();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_trig", 32'(triggered), 32'd0);
        rst_n = 1'b1;
        pix(2, 10, C_BLACK, "mid_rst_2_10");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
